// File: rtl/uart_defs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_defs_pkg : shared UART definitions (map, status bits, states)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_defs_pkg;

    localparam logic [31:0] UART_BASE_ADDR = 32'h0800_0000;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_RX_VALID  = 2;
    localparam int STAT_RX_OVR    = 3;
    localparam int STAT_FRAME_ERR = 4;

    localparam int   FRAME_DATA_BITS = 8;
    localparam int   FRAME_BITS      = 10;
    localparam logic LINE_IDLE       = 1'b1;
    localparam logic START_LEVEL     = 1'b0;
    localparam logic STOP_LEVEL      = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, extra pointer MSB separates full/empty |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_wb : Wishbone slave 8N1 UART, TX FIFO and single RX holding reg  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_wb
    import uart_defs_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic        access, data_rd, data_wr, stat_wr;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic        tx_empty;
    logic [31:0] status_word, data_word;
    logic        unused_bits;

    tx_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_byte, tx_byte_n;
    logic        tx_line_n;

    rx_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_s1, rx_s2, rx_load, rx_ferr;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ovr, frame_err;

    assign unused_bits = &{1'b0, wb_sel_i[3:1], wb_dat_i[31:8]};

    assign access  = wb_stb_i & ~wb_ack_o;
    assign data_rd = access & ~wb_we_i & (wb_adr_i == REG_DATA);
    assign data_wr = access &  wb_we_i & (wb_adr_i == REG_DATA)   & wb_sel_i[0];
    assign stat_wr = access &  wb_we_i & (wb_adr_i == REG_STATUS) & wb_sel_i[0];

    assign fifo_push = data_wr & ~fifo_full;
    assign tx_empty  = fifo_empty & (tx_state == TX_IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wb_dat_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word                 = '0;
        status_word[STAT_TX_FULL]   = fifo_full;
        status_word[STAT_TX_EMPTY]  = tx_empty;
        status_word[STAT_RX_VALID]  = rx_valid;
        status_word[STAT_RX_OVR]    = rx_ovr;
        status_word[STAT_FRAME_ERR] = frame_err;
        // A consumed holding register reads back as all zeros.
        data_word = rx_valid ? {23'b0, 1'b1, rx_data} : 32'h0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            if (access)
                wb_dat_o <= wb_we_i ? '0 : ((wb_adr_i == REG_STATUS) ? status_word : data_word);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_load) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end
            // A read landing on the load edge consumes the old byte, so no overrun.
            if (rx_load && rx_valid && !data_rd)
                rx_ovr <= 1'b1;
            else if (stat_wr && wb_dat_i[STAT_RX_OVR])
                rx_ovr <= 1'b0;
            if (rx_ferr)
                frame_err <= 1'b1;
            else if (stat_wr && wb_dat_i[STAT_FRAME_ERR])
                frame_err <= 1'b0;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_byte_n  = tx_byte;
        fifo_pop   = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!fifo_empty) begin
                    tx_state_n = TX_START;
                    fifo_pop   = 1'b1;
                    tx_byte_n  = fifo_rdata;
                end
            end
            TX_START: if (tx_cnt == BIT_LAST) begin
                tx_state_n = TX_DATA;
                tx_bit_n   = '0;
            end
            TX_DATA: if (tx_cnt == BIT_LAST) begin
                if (tx_bit == 3'(FRAME_DATA_BITS - 1))
                    tx_state_n = TX_STOP;
                else
                    tx_bit_n = tx_bit + 3'd1;
            end
            TX_STOP: if (tx_cnt == BIT_LAST) begin
                if (!fifo_empty) begin
                    tx_state_n = TX_START;
                    fifo_pop   = 1'b1;
                    tx_byte_n  = fifo_rdata;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_line_n = START_LEVEL;
            TX_DATA:  tx_line_n = tx_byte_n[tx_bit_n];
            default:  tx_line_n = LINE_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_byte   <= '0;
            uart_tx_o <= LINE_IDLE;
        end else begin
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_bit    <= tx_bit_n;
            tx_byte   <= tx_byte_n;
            uart_tx_o <= tx_line_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_s2 == START_LEVEL)
                    rx_state_n = RX_START;
            end
            RX_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n   = '0;
                rx_bit_n   = '0;
                rx_state_n = (rx_s2 == START_LEVEL) ? RX_DATA : RX_IDLE;
            end
            RX_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                if (rx_bit == 3'(FRAME_DATA_BITS - 1))
                    rx_state_n = RX_STOP;
                else
                    rx_bit_n = rx_bit + 3'd1;
            end
            RX_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_state_n = RX_IDLE;
                rx_load    = (rx_s2 == STOP_LEVEL);
                rx_ferr    = (rx_s2 != STOP_LEVEL);
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_s1    <= LINE_IDLE;
            rx_s2    <= LINE_IDLE;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_s1    <= uart_rx_i;
            rx_s2    <= rx_s1;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_wb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_wb : directed self-checking bench for uart_wb                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_wb;
    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int FRAME      = 10 * CLK_DIV;
    localparam int LOAD_EDGE  = 3 + CLK_DIV / 2 + 9 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        adr = 1'b0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_r;
    logic        ack;
    logic        tx;
    logic        rx = 1'b1;

    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b1;
    logic [7:0] mon_q [$];
    int   mon_t [$];

    uart_wb #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_w),
        .wb_dat_o  (dat_r),
        .wb_we_i   (we),
        .wb_sel_i  (sel),
        .wb_stb_i  (stb),
        .wb_ack_o  (ack),
        .uart_tx_o (tx),
        .uart_rx_i (rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we_v, input logic adr_v, input logic [31:0] wd,
                           output logic [31:0] rd);
        int k;
        stb = 1'b1; we = we_v; adr = adr_v; dat_w = wd; sel = 4'hF;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!ack && k < 8);
        check("ack", ack, 1'b1);
        rd = dat_r;
        stb = 1'b0; we = 1'b0; sel = 4'h0;
    endtask

    task automatic wb_write(input logic a, input logic [31:0] d);
        logic [31:0] r;
        wb_xfer(1'b1, a, d, r);
    endtask

    task automatic wb_read_check(input string tag, input logic a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'h0, r);
        check(tag, r, exp);
    endtask

    // Drives one 8N1 frame; call and returns at posedge+1.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CLK_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_count", mon_q.size(), n);
    endtask

    function automatic logic [7:0] mon_byte(input int i);
        if (i < mon_q.size()) return mon_q[i];
        return 8'bx;
    endfunction

    function automatic int mon_gap(input int i);
        if (i < mon_t.size()) return mon_t[i] - mon_t[i-1];
        return -1;
    endfunction

    // Serial line monitor: samples each bit at its centre.
    initial begin
        int st;
        logic [7:0] b;
        forever begin
            @(posedge clk); #2;
            if (mon_en && rst_n && tx === 1'b0) begin
                st = cyc;
                repeat (CLK_DIV / 2) @(posedge clk);
                #2;
                check("start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(posedge clk);
                    #2;
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(posedge clk);
                #2;
                check("stop_bit", tx, 1'b1);
                mon_q.push_back(b);
                mon_t.push_back(st);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_ack", ack, 1'b0);
        check("rst_dat", dat_r, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        wb_read_check("rst_status", 1'b1, 32'h02);

        // Single TX, first-bit latency
        wb_write(1'b0, 32'hA5);
        check("tx_latency_e0", tx, 1'b1);
        @(posedge clk); #1;
        check("tx_latency_e1", tx, 1'b0);
        wait_frames(1, FRAME + 40);
        check("tx_byte_a5", mon_byte(0), 8'hA5);
        repeat (12) @(posedge clk);
        #1;
        wb_read_check("tx_done_status", 1'b1, 32'h02);

        // FIFO fill, overflow drop, gapless frames
        mon_q.delete();
        mon_t.delete();
        for (int i = 0; i < 9; i++) wb_write(1'b0, i);
        wb_read_check("fifo_full_status", 1'b1, 32'h01);
        wb_write(1'b0, 32'h09);
        wait_frames(9, 9 * FRAME + 100);
        for (int i = 0; i < 9; i++) check("fifo_byte", mon_byte(i), i);
        for (int i = 1; i < 9; i++) check("frame_gap", mon_gap(i), FRAME);
        repeat (FRAME + 40) @(posedge clk);
        #1;
        check("no_tenth_frame", mon_q.size(), 9);
        wb_read_check("fifo_drain_status", 1'b1, 32'h02);

        // RX single byte, consume
        send_rx(8'h3C, 1'b1);
        wb_read_check("rx_data_3c", 1'b0, 32'h13C);
        wb_read_check("rx_data_reread", 1'b0, 32'h000);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        wb_read_check("ovr_status", 1'b1, 32'h0E);
        wb_read_check("ovr_data", 1'b0, 32'h122);
        wb_write(1'b1, 32'h08);
        wb_read_check("ovr_cleared", 1'b1, 32'h02);

        // Start-bit glitch
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (FRAME + 40) @(posedge clk);
        #1;
        wb_read_check("glitch_status", 1'b1, 32'h02);

        // Framing error
        send_rx(8'h5A, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        wb_read_check("ferr_status", 1'b1, 32'h12);
        wb_write(1'b1, 32'h10);
        wb_read_check("ferr_cleared", 1'b1, 32'h02);

        // Read on the exact load edge
        send_rx(8'h55, 1'b1);
        wb_read_check("coll_pre_status", 1'b1, 32'h06);
        fork
            send_rx(8'hC3, 1'b1);
            begin
                repeat (LOAD_EDGE - 1) @(posedge clk);
                #1;
                wb_read_check("coll_old_byte", 1'b0, 32'h155);
            end
        join
        wb_read_check("coll_status", 1'b1, 32'h06);
        wb_read_check("coll_new_byte", 1'b0, 32'h1C3);
        wb_read_check("coll_final", 1'b1, 32'h02);

        // Asynchronous reset mid-frame, partial RX byte discarded
        mon_en = 1'b0;
        wb_write(1'b0, 32'h00);
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_tx_low", tx, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_ack", ack, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_read_check("post_rst_status", 1'b1, 32'h02);
        repeat (FRAME + 40) @(posedge clk);
        #1;
        check("post_rst_tx_idle", tx, 1'b1);
        wb_read_check("post_rst_no_rx", 1'b1, 32'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
